xunit_sha256_round: RTL

Versat functional unit implementing the SHA-256 compression function for one 512-bit block. It sits directly downstream of the message-schedule unit: it consumes that unit's W_t stream (one 32-bit word per cycle, t = 0..63) on in0. It runs the 64 rounds with an internal K_t ROM, adds the result to the chaining value presented on in1..in8, and holds the 8-word digest on out0..out7 until the next run.

---
 rtl/xunit_sha256_round_if.sv | 23 ++
 rtl/xunit_sha256_round.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/xunit_sha256_round_if.sv
// Port bundle for the SHA-256 compression unit: start pulse, W_t stream,
// chaining value, start delay, and the registered digest with its done flag.
interface xunit_sha256_round_if #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
);
  logic               run;
  logic [DATA_W-1:0]  in0;
  logic [DATA_W-1:0]  in1, in2, in3, in4, in5, in6, in7, in8;
  logic [DELAY_W-1:0] delay0;
  logic [DATA_W-1:0]  out0, out1, out2, out3, out4, out5, out6, out7;
  logic               done;

  modport master (
    output run, in0, in1, in2, in3, in4, in5, in6, in7, in8, delay0,
    input  out0, out1, out2, out3, out4, out5, out6, out7, done
  );

  modport slave (
    input  run, in0, in1, in2, in3, in4, in5, in6, in7, in8, delay0,
    output out0, out1, out2, out3, out4, out5, out6, out7, done
  );
endinterface

// File: rtl/xunit_sha256_round.sv
// SHA-256 compression of one 512-bit block: waits delay0 cycles after run,
// consumes W_0..W_63 one per cycle on in0, then adds the working variables
// to the chaining value and holds the digest until the next completed run.
module xunit_sha256_round #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  xunit_sha256_round_if.slave bus
);

  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ROUND, S_FINAL} state_t;

  localparam word_t K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  state_t             state_reg, state_next;
  logic [DELAY_W-1:0] cnt_reg, cnt_next;
  logic [5:0]         idx_reg, idx_next;
  logic               done_reg, done_next;
  word_t              wv_reg  [8];
  word_t              wv_next [8];
  word_t              dig_reg [8];
  word_t              dig_next[8];

  word_t h_in[8];
  word_t src [8];
  word_t rnd [8];
  word_t sum [8];
  word_t k_cur, t1, t2;

  assign h_in[0] = bus.in1;
  assign h_in[1] = bus.in2;
  assign h_in[2] = bus.in3;
  assign h_in[3] = bus.in4;
  assign h_in[4] = bus.in5;
  assign h_in[5] = bus.in6;
  assign h_in[6] = bus.in7;
  assign h_in[7] = bus.in8;

  // Round 0 happens on the WAIT->ROUND edge, so its operands come straight
  // from the chaining value instead of the (stale) working registers.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign src[gi] = (state_reg == S_WAIT) ? h_in[gi] : wv_reg[gi];
      assign sum[gi] = h_in[gi] + wv_reg[gi];
    end
  endgenerate

  // One SHA-256 round on src using W = in0 and K indexed by the round counter.
  always_comb begin
    k_cur  = K_ROM[idx_reg];
    t1     = src[7]
           + (rotr(src[4], 6) ^ rotr(src[4], 11) ^ rotr(src[4], 25))
           + ((src[4] & src[5]) ^ (~src[4] & src[6]))
           + k_cur + bus.in0;
    t2     = (rotr(src[0], 2) ^ rotr(src[0], 13) ^ rotr(src[0], 22))
           + ((src[0] & src[1]) ^ (src[0] & src[2]) ^ (src[1] & src[2]));
    rnd[0] = t1 + t2;
    rnd[1] = src[0];
    rnd[2] = src[1];
    rnd[3] = src[2];
    rnd[4] = src[3] + t1;
    rnd[5] = src[4];
    rnd[6] = src[5];
    rnd[7] = src[6];
  end

  // Sequencing: delay countdown, 64 rounds, final add; run restarts from any state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    done_next  = done_reg;
    wv_next    = wv_reg;
    dig_next   = dig_reg;
    case (state_reg)
      S_IDLE: ;
      S_WAIT: begin
        if (cnt_reg == '0) begin
          wv_next    = rnd;
          idx_next   = 6'd1;
          state_next = S_ROUND;
        end else begin
          cnt_next = cnt_reg - DELAY_W'(1);
        end
      end
      S_ROUND: begin
        wv_next  = rnd;
        idx_next = idx_reg + 6'd1;
        if (idx_reg == 6'd63) state_next = S_FINAL;
      end
      S_FINAL: begin
        dig_next   = sum;
        done_next  = 1'b1;
        idx_next   = 6'd0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // A new run wins over everything, including a pending digest write.
    if (bus.run) begin
      state_next = S_WAIT;
      cnt_next   = bus.delay0;
      idx_next   = 6'd0;
      done_next  = 1'b0;
      dig_next   = dig_reg;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      done_reg  <= 1'b1;
      for (int k = 0; k < 8; k++) begin
        wv_reg[k]  <= '0;
        dig_reg[k] <= '0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
      wv_reg    <= wv_next;
      dig_reg   <= dig_next;
    end
  end

  assign bus.out0 = dig_reg[0];
  assign bus.out1 = dig_reg[1];
  assign bus.out2 = dig_reg[2];
  assign bus.out3 = dig_reg[3];
  assign bus.out4 = dig_reg[4];
  assign bus.out5 = dig_reg[5];
  assign bus.out6 = dig_reg[6];
  assign bus.out7 = dig_reg[7];
  assign bus.done = done_reg;

endmodule
